fcs32_bitp_tx: RTL

//  Bit-serial Ethernet-style transmitter: accepts frame bytes over a valid/ready handshake, shifts

---
 rtl/fcs32_bitp_pkg.sv | 33 +++
 rtl/fcs32_bitp_tx_shift.sv | 44 ++++
 rtl/fcs32_bitp_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fcs32_bitp_pkg.sv
// Shared constants, state encoding and the bit-serial CRC-32 helpers for the FCS transmitter.
package fcs32_bitp_pkg;

    localparam logic        LO      = 1'b0;
    localparam logic        HI      = 1'b1;
    localparam logic [31:0] ONES    = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_FCS  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // One CRC-32 step, MSB-aligned register, fed one wire bit at a time.
    function automatic logic [31:0] fcs32_1(input logic b, input logic [31:0] crc);
        logic fb;
        fb = crc[31] ^ b;
        return {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    endfunction

    // FCS word as sent on the wire: bit-reversed and inverted CRC register.
    function automatic logic [31:0] fcs32_brev(input logic [31:0] crc);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = ~crc[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fcs32_bitp_tx_shift.sv
// LSB-first shift register with bit counter; serves data bytes, the FCS word and the gap timer.
module fcs32_bitp_tx_shift #(
    parameter int CNT_W = 7
) (
    input  logic             bclk_i,
    input  logic             brst_n_i,
    input  logic             ld_i,
    input  logic [31:0]      ld_dat_i,
    input  logic             clr_i,
    output logic             bit_o,
    output logic             bstb_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [31:0]      sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sh_d  = {1'b0, sh_q[31:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (ld_i) begin
            sh_d  = ld_dat_i;
            cnt_d = '0;
        end else if (clr_i) begin
            sh_d  = sh_q;
            cnt_d = '0;
        end
    end

    always_ff @(posedge bclk_i or negedge brst_n_i) begin
        if (!brst_n_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o  = sh_q[0];
    assign bstb_o = (cnt_q[2:0] == 3'd0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fcs32_bitp_tx.sv
// Bit-serial frame transmitter: byte handshake in, LSB-first bits out with CRC-32 FCS and idle gap.
//  state | meaning
//  IDLE  | waiting for a sof byte; rdy_o high
//  DATA  | shifting frame byte bits 0..7, CRC running
//  FCS   | shifting the 32-bit FCS word
//  GAP   | forced idle for GAP_BITS bit times
module fcs32_bitp_tx
    import fcs32_bitp_pkg::*;
#(
    parameter int GAP_BITS = 96
) (
    input  logic       bclk_i,
    input  logic       brst_n_i,
    input  logic [7:0] dat_i,
    input  logic       sof_i,
    input  logic       eof_i,
    input  logic       val_i,
    output logic       rdy_o,
    output logic       bit_o,
    output logic       bval_o,
    output logic       bstb_o,
    output logic       sof_o,
    output logic       eof_o,
    output logic       err_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2((GAP_BITS > 32) ? GAP_BITS : 32);
    localparam logic [CNT_W-1:0] CNT_7   = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_31  = CNT_W'(31);
    localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(GAP_BITS - 1);

    state_e           state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic             eof_cur_q, eof_cur_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic             sh_ld, sh_clr, sh_bit, sh_bstb;
    logic [31:0]      sh_ld_dat;
    logic [CNT_W-1:0] cnt;
    logic             in_data, in_fcs;

    fcs32_bitp_tx_shift #(.CNT_W(CNT_W)) u_shift (
        .bclk_i   (bclk_i),
        .brst_n_i (brst_n_i),
        .ld_i     (sh_ld),
        .ld_dat_i (sh_ld_dat),
        .clr_i    (sh_clr),
        .bit_o    (sh_bit),
        .bstb_o   (sh_bstb),
        .cnt_o    (cnt)
    );

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        eof_cur_d = eof_cur_q;
        first_d   = first_q;
        err_d     = LO;
        sh_ld     = LO;
        sh_ld_dat = 32'h0;
        sh_clr    = LO;
        rdy_o     = LO;
        unique case (state_q)
            ST_IDLE: begin
                sh_clr = HI;
                rdy_o  = brst_n_i;
                if (val_i) begin
                    if (sof_i) begin
                        sh_ld     = HI;
                        sh_ld_dat = {24'h0, dat_i};
                        crc_d     = ONES;
                        eof_cur_d = eof_i;
                        first_d   = HI;
                        state_d   = ST_DATA;
                    end else begin
                        err_d = HI;
                    end
                end
            end
            ST_DATA: begin
                crc_d = fcs32_1(sh_bit, crc_q);
                if (cnt == CNT_7) begin
                    if (eof_cur_q) begin
                        sh_ld     = HI;
                        sh_ld_dat = fcs32_brev(crc_d);
                        state_d   = ST_FCS;
                    end else begin
                        rdy_o = brst_n_i;
                        if (val_i) begin
                            // mid-frame sof_i is deliberately ignored
                            sh_ld     = HI;
                            sh_ld_dat = {24'h0, dat_i};
                            eof_cur_d = eof_i;
                            first_d   = LO;
                        end else begin
                            err_d   = HI;
                            sh_clr  = HI;
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_FCS: begin
                if (cnt == CNT_31) begin
                    sh_clr  = HI;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == CNT_GAP) begin
                    sh_clr  = HI;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge bclk_i or negedge brst_n_i) begin
        if (!brst_n_i) begin
            state_q   <= ST_IDLE;
            crc_q     <= ONES;
            eof_cur_q <= LO;
            first_q   <= LO;
            err_q     <= LO;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            eof_cur_q <= eof_cur_d;
            first_q   <= first_d;
            err_q     <= err_d;
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign in_data = (state_q == ST_DATA);
    assign in_fcs  = (state_q == ST_FCS);
    assign bval_o  = in_data | in_fcs;
    assign bit_o   = bval_o & sh_bit;
    assign bstb_o  = bval_o & sh_bstb;
    assign sof_o   = in_data & first_q & (cnt == '0);
    assign eof_o   = in_fcs & (cnt == CNT_31);
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule
